qph_user_clk_rcfg_seq: RTL and testbench



---
 rtl/qph_user_clk_rcfg_seq.sv | 267 ++++++++++++++++++++++++++
 tb/tb_qph_user_clk_rcfg_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qph_user_clk_rcfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : qph_user_clk_rcfg_seq
// Brief    : Table-driven sequencer that replays PLL register writes over the
//            user-clock reconfiguration command/status words, then pulses the PLL reset and waits for lock.
// Revision : 1.0 - initial release
// ============================================================================
module qph_user_clk_rcfg_seq #(
    parameter int MAX_ENTRIES  = 8,
    parameter int RST_CYCLES   = 16,
    parameter int ACK_TIMEOUT  = 1024,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tbl_we,
    input  logic [2:0]  tbl_idx,
    input  logic [9:0]  tbl_addr,
    input  logic [7:0]  tbl_data,
    input  logic [3:0]  num_entries,
    input  logic        start,
    output logic [63:0] user_clk_freq_cmd_0,
    input  logic [63:0] user_clk_freq_sts_0,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int c_settle_cycles = 8;
    localparam int c_max_a = (RST_CYCLES > ACK_TIMEOUT) ? RST_CYCLES : ACK_TIMEOUT;
    localparam int c_max_b = (LOCK_TIMEOUT > c_settle_cycles) ? LOCK_TIMEOUT : c_settle_cycles;
    localparam int c_cnt_max = (c_max_a > c_max_b) ? c_max_a : c_max_b;
    localparam int CW = $clog2(c_cnt_max + 1);

    localparam logic [CW-1:0] c_rst_last    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] c_settle_last = CW'(c_settle_cycles - 1);
    localparam logic [CW-1:0] c_ack_last    = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] c_lock_last   = CW'(LOCK_TIMEOUT - 1);

    localparam logic [63:0] c_cmd_idle    = 64'h0010_0000_0000_0000;
    localparam logic [63:0] c_cmd_fsm_rst = 64'h0100_0000_0000_0000;
    localparam logic [4:0]  c_max_entries = 5'(MAX_ENTRIES);

    localparam logic [1:0] c_err_ack  = 2'd1;
    localparam logic [1:0] c_err_fsm  = 2'd2;
    localparam logic [1:0] c_err_lock = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FSM_RST   = 4'd1,
        S_SETTLE    = 4'd2,
        S_ISSUE     = 4'd3,
        S_WAIT_ACK  = 4'd4,
        S_PLL_RST   = 4'd5,
        S_WAIT_LOCK = 4'd6,
        S_DONE      = 4'd7,
        S_ERR       = 4'd8
    } state_t;

    state_t       r_state;
    logic [63:0]  r_cmd;
    logic [1:0]   r_seq;
    logic [2:0]   r_idx;
    logic [3:0]   r_num;
    logic [CW-1:0] r_cnt;
    logic         r_lock_q;
    logic         r_busy;
    logic         r_done;
    logic         r_err;
    logic [1:0]   r_err_code;

    logic [9:0]   r_tbl_addr [MAX_ENTRIES];
    logic [7:0]   r_tbl_data [MAX_ENTRIES];

    logic         w_num_ok;
    logic         w_ack;
    logic         w_last;
    logic [2:0]   w_next_idx;
    logic [1:0]   w_next_seq;
    logic         w_unused;

    // Table is writable in any state; entries are sampled only when issued,
    // so a write while busy lands only on entries still ahead of the index.
    generate
        for (genvar gi = 0; gi < MAX_ENTRIES; gi++) begin : g_tbl
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tbl_addr[gi] <= '0;
                    r_tbl_data[gi] <= '0;
                end else if (tbl_we && (tbl_idx == 3'(gi))) begin
                    r_tbl_addr[gi] <= tbl_addr;
                    r_tbl_data[gi] <= tbl_data;
                end
            end
        end
    endgenerate

    function automatic logic [63:0] f_issue(input logic [1:0] seq,
                                            input logic [9:0] addr,
                                            input logic [7:0] data);
        logic [63:0] v;
        v          = c_cmd_idle;
        v[49:48]   = seq;
        v[44]      = 1'b1;
        v[41:32]   = addr;
        v[7:0]     = data;
        return v;
    endfunction

    assign w_num_ok   = (num_entries != 4'd0) && ({1'b0, num_entries} <= c_max_entries);
    assign w_ack      = (user_clk_freq_sts_0[49:48] == r_cmd[49:48]) &&
                        user_clk_freq_sts_0[44] &&
                        (user_clk_freq_sts_0[41:32] == r_cmd[41:32]);
    assign w_next_idx = r_idx + 3'd1;
    assign w_next_seq = r_seq + 2'd1;
    assign w_last     = (({1'b0, r_idx} + 4'd1) == r_num);

    assign w_unused = ^{user_clk_freq_sts_0[62:61], user_clk_freq_sts_0[59:50],
                        user_clk_freq_sts_0[47:45], user_clk_freq_sts_0[43:42],
                        user_clk_freq_sts_0[31:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cmd      <= c_cmd_idle;
            r_seq      <= 2'd0;
            r_idx      <= 3'd0;
            r_num      <= 4'd0;
            r_cnt      <= '0;
            r_lock_q   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        if (w_num_ok) begin
                            r_state    <= S_FSM_RST;
                            r_cmd      <= c_cmd_fsm_rst;
                            r_seq      <= 2'd0;
                            r_idx      <= 3'd0;
                            r_num      <= num_entries;
                            r_cnt      <= '0;
                            r_busy     <= 1'b1;
                            r_err      <= 1'b0;
                            r_err_code <= 2'd0;
                        end else begin
                            r_state    <= S_ERR;
                            r_cmd      <= c_cmd_idle;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                            r_err_code <= c_err_ack;
                        end
                    end
                end

                S_FSM_RST: begin
                    if (r_cnt == c_rst_last) begin
                        r_state <= S_SETTLE;
                        r_cmd   <= c_cmd_idle;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_SETTLE: begin
                    if (r_cnt == c_settle_last) begin
                        r_state <= S_ISSUE;
                        r_seq   <= w_next_seq;
                        r_cmd   <= f_issue(w_next_seq, r_tbl_addr[r_idx], r_tbl_data[r_idx]);
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_ISSUE: begin
                    r_state <= S_WAIT_ACK;
                    r_cnt   <= '0;
                end

                S_WAIT_ACK: begin
                    // A reported FSM error outranks an echo arriving in the same cycle.
                    if (user_clk_freq_sts_0[63]) begin
                        r_state    <= S_ERR;
                        r_cmd      <= c_cmd_idle;
                        r_busy     <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= c_err_fsm;
                    end else if (w_ack) begin
                        r_cnt <= '0;
                        if (w_last) begin
                            r_state    <= S_PLL_RST;
                            r_cmd[57]  <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                            r_idx   <= w_next_idx;
                            r_seq   <= w_next_seq;
                            r_cmd   <= f_issue(w_next_seq, r_tbl_addr[w_next_idx],
                                               r_tbl_data[w_next_idx]);
                        end
                    end else if (r_cnt == c_ack_last) begin
                        r_state    <= S_ERR;
                        r_cmd      <= c_cmd_idle;
                        r_busy     <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= c_err_ack;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_PLL_RST: begin
                    if (r_cnt == c_rst_last) begin
                        r_state   <= S_WAIT_LOCK;
                        r_cmd[57] <= 1'b0;
                        r_cnt     <= '0;
                        r_lock_q  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_WAIT_LOCK: begin
                    r_lock_q <= user_clk_freq_sts_0[60];
                    if (user_clk_freq_sts_0[60] && r_lock_q) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (r_cnt == c_lock_last) begin
                        r_state    <= S_ERR;
                        r_cmd      <= c_cmd_idle;
                        r_busy     <= 1'b0;
                        r_err      <= 1'b1;
                        r_err_code <= c_err_lock;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cmd   <= c_cmd_idle;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cmd   <= c_cmd_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign user_clk_freq_cmd_0 = r_cmd;
    assign busy                = r_busy;
    assign done                = r_done;
    assign err                 = r_err;
    assign err_code            = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_qph_user_clk_rcfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_qph_user_clk_rcfg_seq
// Brief    : Randomized bench with an echoing responder and a command-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qph_user_clk_rcfg_seq;

    localparam int RST_CYCLES   = 16;
    localparam int ACK_TIMEOUT  = 1024;
    localparam int LOCK_TIMEOUT = 65536;
    localparam int BUDGET       = 70000;
    localparam logic [63:0] CMD_IDLE = 64'h0010_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        tbl_we;
    logic [2:0]  tbl_idx;
    logic [9:0]  tbl_addr;
    logic [7:0]  tbl_data;
    logic [3:0]  num_entries;
    logic        start;
    logic [63:0] cmd;
    logic [63:0] sts;
    logic        busy, done, err;
    logic [1:0]  err_code;

    qph_user_clk_rcfg_seq dut (
        .clk                 (clk),
        .rst                 (rst),
        .tbl_we              (tbl_we),
        .tbl_idx             (tbl_idx),
        .tbl_addr            (tbl_addr),
        .tbl_data            (tbl_data),
        .num_entries         (num_entries),
        .start               (start),
        .user_clk_freq_cmd_0 (cmd),
        .user_clk_freq_sts_0 (sts),
        .busy                (busy),
        .done                (done),
        .err                 (err),
        .err_code            (err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Responder: 0 = echo, 1 = silent, 2 = echo with FSM error flag
    int resp_mode  = 0;
    int resp_delay = 5;
    bit lock_en    = 1'b1;

    initial begin : responder
        logic [12:0] key;
        logic [12:0] last_key;
        bit          key_vld;
        int          cd;
        sts      = '0;
        key_vld  = 1'b0;
        last_key = '0;
        cd       = 0;
        forever begin
            @(negedge clk);
            key = {cmd[49:48], cmd[44], cmd[41:32]};
            if (!busy) sts = '0;
            if (!cmd[44]) begin
                key_vld = 1'b0;
                cd      = 0;
            end else if (!key_vld || key != last_key) begin
                key_vld  = 1'b1;
                last_key = key;
                cd       = resp_delay;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0 && resp_mode != 1) begin
                    sts[49:48] = cmd[49:48];
                    sts[44]    = 1'b1;
                    sts[41:32] = cmd[41:32];
                    sts[63]    = (resp_mode == 2);
                end
            end
            sts[60] = lock_en;
        end
    end

    // Monitor: logs each newly issued command and counts pulse widths
    int          run_id = 0;
    logic [63:0] obs[$];
    int          mgmt_cnt, pll_cnt, done_cnt, wack_cnt, lock_cnt;

    initial begin : monitor
        int          seen_id;
        bit          prev_wr;
        logic [63:0] prev_cmd;
        seen_id  = -1;
        prev_wr  = 1'b0;
        prev_cmd = '0;
        forever begin
            @(negedge clk);
            if (run_id != seen_id) begin
                seen_id  = run_id;
                obs.delete();
                mgmt_cnt = 0; pll_cnt = 0; done_cnt = 0; wack_cnt = 0; lock_cnt = 0;
                prev_wr  = 1'b0;
            end
            if (cmd[44] && (!prev_wr || cmd[49:0] != prev_cmd[49:0])) obs.push_back(cmd);
            prev_wr  = cmd[44];
            prev_cmd = cmd;
            if (cmd[56]) mgmt_cnt++;
            if (cmd[57]) pll_cnt++;
            if (done) done_cnt++;
            if (busy && cmd[44]) wack_cnt++;
            if (busy && !done && pll_cnt > 0 && !cmd[57]) lock_cnt++;
        end
    end

    // Reference table contents as the sequencer should see them
    logic [9:0] m_addr [8];
    logic [7:0] m_data [8];

    function automatic logic [63:0] exp_cmd(input int k);
        logic [63:0] v;
        v        = CMD_IDLE;
        v[49:48] = 2'((k + 1) % 4);
        v[44]    = 1'b1;
        v[41:32] = m_addr[k];
        v[31:0]  = {24'h0, m_data[k]};
        return v;
    endfunction

    task automatic tbl_write(input int idx, input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        tbl_we   = 1'b1;
        tbl_idx  = 3'(idx);
        tbl_addr = a;
        tbl_data = d;
        @(negedge clk);
        tbl_we   = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic rand_table(input int n);
        for (int k = 0; k < n; k++) begin
            m_addr[k] = 10'($urandom);
            m_data[k] = 8'($urandom);
        end
    endtask

    // mode: 0 ok, 1 no echo, 2 FSM error, 3 no lock, 4 invalid count
    task automatic run_seq(input int n, input int mode, input bit load,
                           input bit tweak, input bit stray);
        int         exp_n;
        logic [1:0] exp_code;
        bit         fin;
        bit         tweaked;
        if (load) for (int k = 0; k < n && k < 8; k++) tbl_write(k, m_addr[k], m_data[k]);
        resp_mode = (mode == 1) ? 1 : (mode == 2) ? 2 : 0;
        lock_en   = (mode != 3);
        if (tweak && resp_delay < 4) resp_delay = 4;
        num_entries = 4'(n);
        run_id++;
        pulse_start();
        check($sformatf("busy_after_start_m%0d", mode), {63'd0, busy}, (mode == 4) ? 64'd0 : 64'd1);
        fin = 1'b0;
        tweaked = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (tweak && !tweaked && n >= 2 && obs.size() >= 1) begin
                tweaked = 1'b1;
                m_addr[n-1] = 10'($urandom);
                m_data[n-1] = 8'($urandom);
                tbl_write(n - 1, m_addr[n-1], m_data[n-1]);
                tbl_write(0, ~m_addr[0], ~m_data[0]);
            end
            if (stray && c == 20) pulse_start();
            if (done_cnt > 0 || (err && !busy)) begin
                fin = 1'b1;
                break;
            end
        end
        check("run_finished", {63'd0, fin}, 64'd1);
        repeat (2) @(negedge clk);

        exp_n    = (mode == 4) ? 0 : (mode == 1 || mode == 2) ? 1 : n;
        exp_code = (mode == 4) ? 2'd1 : 2'(mode);
        check("num_cmds", 64'(obs.size()), 64'(exp_n));
        for (int k = 0; k < exp_n && k < obs.size(); k++)
            check($sformatf("cmd%0d", k), obs[k], exp_cmd(k));
        check("err", {63'd0, err}, (mode == 0) ? 64'd0 : 64'd1);
        check("err_code", {62'd0, err_code}, {62'd0, exp_code});
        check("done_pulses", 64'(done_cnt), (mode == 0) ? 64'd1 : 64'd0);
        check("pll_rst_len", 64'(pll_cnt), (mode == 0 || mode == 3) ? 64'(RST_CYCLES) : 64'd0);
        check("mgmt_rst_len", 64'(mgmt_cnt), (mode == 4) ? 64'd0 : 64'(RST_CYCLES));
        check("busy_end", {63'd0, busy}, 64'd0);
        check("cmd_end", cmd, CMD_IDLE);
        if (mode == 1) check("ack_timeout_len", 64'(wack_cnt), 64'(1 + ACK_TIMEOUT));
        if (mode == 0) check("lock_wait_len", 64'(lock_cnt), 64'd2);
        if (mode == 3) check("lock_timeout_len", 64'(lock_cnt), 64'(LOCK_TIMEOUT));
    endtask

    initial begin : main
        bit fin;
        int n;
        rst = 1'b1; tbl_we = 1'b0; tbl_idx = '0; tbl_addr = '0; tbl_data = '0;
        num_entries = '0; start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd", cmd, CMD_IDLE);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_err_code", {62'd0, err_code}, 64'd0);

        // Three-entry reference sequence with a five-cycle echo
        m_addr[0] = 10'h11b; m_data[0] = 8'h05;
        m_addr[1] = 10'h11e; m_data[1] = 8'h05;
        m_addr[2] = 10'h000; m_data[2] = 8'h01;
        resp_delay = 5;
        run_seq(3, 0, 1'b1, 1'b0, 1'b0);

        // Five entries: sequence number wraps 3 -> 0
        rand_table(5);
        run_seq(5, 0, 1'b1, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 8);
            rand_table(n);
            resp_delay = $urandom_range(1, 7);
            run_seq(n, 0, 1'b1, (r % 2) == 0, (r % 3) == 1);
        end

        rand_table(4);
        resp_delay = 3;
        run_seq(4, 1, 1'b1, 1'b0, 1'b0);
        run_seq(4, 2, 1'b1, 1'b0, 1'b0);
        run_seq(0, 4, 1'b0, 1'b0, 1'b0);
        run_seq(9, 4, 1'b0, 1'b0, 1'b0);
        run_seq($urandom_range(10, 15), 4, 1'b0, 1'b0, 1'b0);

        rand_table(2);
        run_seq(2, 3, 1'b1, 1'b0, 1'b0);
        rand_table(3);
        run_seq(3, 0, 1'b1, 1'b0, 1'b0);

        // Reset during the second wait for echo
        rand_table(3);
        for (int k = 0; k < 3; k++) tbl_write(k, m_addr[k], m_data[k]);
        resp_mode = 0; lock_en = 1'b1; resp_delay = 20;
        num_entries = 4'd3;
        run_id++;
        pulse_start();
        fin = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (obs.size() >= 2) begin
                fin = 1'b1;
                break;
            end
        end
        check("rst_reach_2nd", {63'd0, fin}, 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_cmd", cmd, CMD_IDLE);
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_no_more_cmds", 64'(obs.size()), 64'd2);
        check("rst_idle_busy", {63'd0, busy}, 64'd0);
        check("rst_idle_err", {63'd0, err}, 64'd0);
        run_seq(0, 4, 1'b0, 1'b0, 1'b0);

        // Reset must have cleared every table entry
        for (int k = 0; k < 8; k++) begin
            m_addr[k] = '0;
            m_data[k] = '0;
        end
        resp_delay = 2;
        run_seq(8, 0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
